// File: rtl/anton_neopixel_stream_sequencer.sv
// NeoPixel stream sequencer: walks the pixel buffer one byte at a time and
// feeds the bit encoder MSB first, then holds the line low for the LATCH
// period and pulses streamSyncOf so the register block can clear or keep run.
module anton_neopixel_stream_sequencer #(
    parameter  int BUFFER_END   = 7,
    parameter  int RESET_CYCLES = 2500,
    localparam int BUFFER_BITS  = (BUFFER_END > 0) ? $clog2(BUFFER_END + 1) : 1
) (
    input  logic                   busClk,
    input  logic                   busReset,
    input  logic                   regCtrlRun,
    input  logic                   regCtrlLimit,
    input  logic                   regCtrl32bit,
    input  logic [12:0]            regMax,
    input  logic [7:0]             pixelByte,
    input  logic                   bitReady,
    output logic [BUFFER_BITS-1:0] byteAddr,
    output logic                   bitValid,
    output logic                   bitValue,
    output logic                   state,
    output logic                   streamSyncOf
);

    // Latch counter only has to hold RESET_CYCLES-1.
    localparam int                  CNT_BITS  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LOAD  = CNT_BITS'(RESET_CYCLES - 1);
    localparam logic [13:0]         BUF_END_W = 14'(BUFFER_END);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_LATCH = 2'd2
    } fsm_t;

    fsm_t                   fsm_q, fsm_d;
    logic [BUFFER_BITS-1:0] addr_q, addr_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic                   mode32_q, mode32_d;
    logic                   limit_q, limit_d;
    logic                   sync_q, sync_d;

    logic [13:0]            addr_wide;
    logic [13:0]            next_addr;
    logic [13:0]            end_addr;
    logic                   last_byte;
    logic                   handshake;

    // Address arithmetic, 14 bits wide so the increment can never wrap.
    always_comb begin
        addr_wide = 14'(addr_q);
        // In 32-bit mode the byte at offset 3 of each pixel is skipped.
        if (mode32_q && (addr_wide[1:0] == 2'd2)) begin
            next_addr = addr_wide + 14'd2;
        end else begin
            next_addr = addr_wide + 14'd1;
        end
        if (limit_q && ({1'b0, regMax} < BUF_END_W)) begin
            end_addr = {1'b0, regMax};
        end else begin
            end_addr = BUF_END_W;
        end
        last_byte = (next_addr > end_addr);
    end

    assign handshake = (fsm_q == ST_DATA) && bitReady;

    // State register and all sequencing registers.
    always_ff @(posedge busClk) begin
        if (busReset) begin
            fsm_q     <= ST_IDLE;
            addr_q    <= '0;
            bit_idx_q <= 3'd7;
            cnt_q     <= '0;
            mode32_q  <= 1'b0;
            limit_q   <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            addr_q    <= addr_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            mode32_q  <= mode32_d;
            limit_q   <= limit_d;
            sync_q    <= sync_d;
        end
    end

    // Next-state logic: frame start, bit/byte stepping, abort and latch timing.
    always_comb begin
        fsm_d     = fsm_q;
        addr_d    = addr_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        mode32_d  = mode32_q;
        limit_d   = limit_q;
        sync_d    = 1'b0;

        case (fsm_q)
            ST_IDLE: begin
                // Run is ignored during the sync cycle: the register block
                // updates it on that same edge.
                if (regCtrlRun && !sync_q) begin
                    mode32_d  = regCtrl32bit;
                    limit_d   = regCtrlLimit;
                    addr_d    = '0;
                    bit_idx_d = 3'd7;
                    fsm_d     = ST_DATA;
                end
            end

            ST_DATA: begin
                if (handshake) begin
                    if (bit_idx_q != 3'd0) begin
                        bit_idx_d = bit_idx_q - 3'd1;
                    end else begin
                        bit_idx_d = 3'd7;
                    end
                end
                // Abort takes priority over address advance; a same-cycle
                // handshake still consumes its bit.
                if (!regCtrlRun) begin
                    fsm_d = ST_LATCH;
                    cnt_d = CNT_LOAD;
                end else if (handshake && (bit_idx_q == 3'd0)) begin
                    if (last_byte) begin
                        fsm_d = ST_LATCH;
                        cnt_d = CNT_LOAD;
                    end else begin
                        addr_d = next_addr[BUFFER_BITS-1:0];
                    end
                end
            end

            ST_LATCH: begin
                if (cnt_q == '0) begin
                    fsm_d  = ST_IDLE;
                    sync_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end
            end

            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    assign byteAddr     = addr_q;
    assign bitValid     = (fsm_q == ST_DATA);
    assign bitValue     = (fsm_q == ST_DATA) && pixelByte[bit_idx_q];
    assign state        = (fsm_q == ST_LATCH);
    assign streamSyncOf = sync_q;

endmodule

// File: tb/tb_anton_neopixel_stream_sequencer.sv
// Self-checking bench for the NeoPixel stream sequencer: table-driven frames,
// loop/abort/reset corner sequences, and randomized frames against a model.
module tb_anton_neopixel_stream_sequencer;

    localparam int BEND = 7;
    localparam int RC   = 12;

    logic        busClk = 1'b0;
    logic        busReset;
    logic        regCtrlRun;
    logic        regCtrlLimit;
    logic        regCtrl32bit;
    logic [12:0] regMax;
    logic [7:0]  pixelByte;
    logic        bitReady;
    logic [2:0]  byteAddr;
    logic        bitValid;
    logic        bitValue;
    logic        state;
    logic        streamSyncOf;

    logic [7:0]  mem [0:7];
    int          checks   = 0;
    int          failures = 0;

    typedef struct {
        bit m32;
        bit lim;
        int rmax;
        int pct;
        int abort_bits;
        int exp_bits;
    } vec_t;

    vec_t vecs [10];

    always #5 busClk = ~busClk;

    assign pixelByte = mem[byteAddr];

    anton_neopixel_stream_sequencer #(
        .BUFFER_END  (BEND),
        .RESET_CYCLES(RC)
    ) dut (
        .busClk      (busClk),
        .busReset    (busReset),
        .regCtrlRun  (regCtrlRun),
        .regCtrlLimit(regCtrlLimit),
        .regCtrl32bit(regCtrl32bit),
        .regMax      (regMax),
        .pixelByte   (pixelByte),
        .bitReady    (bitReady),
        .byteAddr    (byteAddr),
        .bitValid    (bitValid),
        .bitValue    (bitValue),
        .state       (state),
        .streamSyncOf(streamSyncOf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One whole frame: start, DATA checked bit by bit against the model's
    // byte list, LATCH length, sync pulse and the two cycles after it.
    task automatic run_frame(input string tag, input bit m32, input bit lim,
                             input int rmax, input int pct, input int abort_in,
                             input bit keep_run, input bit wiggle, input int exp_bits);
        int          addrs[$];
        int          end_a;
        int          total;
        int          target;
        int          abort_bits;
        int          sent;
        int          cyc;
        int          drop_cycles;
        bit          dropped;
        logic [7:0]  b;

        end_a = lim ? ((rmax < BEND) ? rmax : BEND) : BEND;
        for (int a = 0; a <= end_a; a++) begin
            if (!(m32 && (a % 4 == 3))) addrs.push_back(a);
        end
        total      = addrs.size() * 8;
        abort_bits = (abort_in >= 0 && abort_in < total) ? abort_in : -1;
        target     = (abort_bits >= 0) ? abort_bits : total;

        @(posedge busClk); #1;
        regCtrl32bit = m32;
        regCtrlLimit = lim;
        regMax       = 13'(rmax);
        regCtrlRun   = 1'b1;
        bitReady     = 1'b0;
        @(negedge busClk);
        chk({tag, " idle before start"}, {29'd0, state, bitValid, streamSyncOf}, 32'd0);

        sent = 0; cyc = 0; drop_cycles = 0; dropped = 0;
        forever begin
            @(posedge busClk); #1;
            if (wiggle) begin
                regCtrl32bit = 1'($urandom);
                regCtrlLimit = 1'($urandom);
            end
            if (abort_bits >= 0 && sent >= abort_bits) begin
                regCtrlRun = 1'b0;
                bitReady   = 1'b0;
                dropped    = 1;
            end else begin
                bitReady = ($urandom_range(99) < pct);
            end
            @(negedge busClk);
            if (!bitValid) break;
            if (dropped) drop_cycles++;
            if (sent < total) begin
                b = mem[addrs[sent / 8]];
                chk({tag, " addr"}, 32'(byteAddr), addrs[sent / 8]);
                chk({tag, " bit"}, 32'(bitValue), 32'(b[7 - (sent % 8)]));
            end else begin
                chk({tag, " extra DATA cycle"}, 32'(bitValid), 32'd0);
            end
            if (bitReady) sent++;
            cyc++;
            if (cyc > 2000) begin
                checks++;
                failures++;
                $display("FAIL %s timeout: got no LATCH expected LATCH within 2000 cycles", tag);
                return;
            end
        end

        chk({tag, " latch entry"}, {29'd0, state, bitValid, streamSyncOf}, 32'b100);
        chk({tag, " bits sent"}, sent, target);
        if (exp_bits >= 0) chk({tag, " bits vs table"}, sent, exp_bits);
        if (abort_bits >= 0) chk({tag, " abort DATA cycles"}, drop_cycles, 1);

        for (int i = 1; i < RC; i++) begin
            @(posedge busClk); #1;
            @(negedge busClk);
            chk({tag, " latch hold"}, {29'd0, state, bitValid, streamSyncOf}, 32'b100);
        end

        @(posedge busClk); #1;
        if (!keep_run) regCtrlRun = 1'b0;
        @(negedge busClk);
        chk({tag, " sync pulse"}, {29'd0, state, bitValid, streamSyncOf}, 32'b001);

        @(posedge busClk); #1;
        @(negedge busClk);
        chk({tag, " after sync"}, {29'd0, state, bitValid, streamSyncOf}, 32'b000);

        @(posedge busClk); #1;
        bitReady = 1'b0;
        @(negedge busClk);
        if (keep_run) begin
            b = mem[0];
            chk({tag, " restart valid"}, {29'd0, state, bitValid, streamSyncOf}, 32'b010);
            chk({tag, " restart addr"}, 32'(byteAddr), 32'd0);
            chk({tag, " restart msb"}, 32'(bitValue), 32'(b[7]));
        end else begin
            chk({tag, " stays idle"}, {29'd0, state, bitValid, streamSyncOf}, 32'b000);
        end
    endtask

    initial begin
        vecs[0] = '{m32: 0, lim: 0, rmax: 0,   pct: 100, abort_bits: -1, exp_bits: 64};
        vecs[1] = '{m32: 1, lim: 0, rmax: 0,   pct: 100, abort_bits: -1, exp_bits: 48};
        vecs[2] = '{m32: 0, lim: 1, rmax: 2,   pct: 100, abort_bits: -1, exp_bits: 24};
        vecs[3] = '{m32: 0, lim: 1, rmax: 100, pct: 100, abort_bits: -1, exp_bits: 64};
        vecs[4] = '{m32: 0, lim: 1, rmax: 0,   pct: 100, abort_bits: -1, exp_bits: 8};
        vecs[5] = '{m32: 1, lim: 1, rmax: 3,   pct: 100, abort_bits: -1, exp_bits: 24};
        vecs[6] = '{m32: 1, lim: 1, rmax: 4,   pct: 100, abort_bits: -1, exp_bits: 32};
        vecs[7] = '{m32: 0, lim: 0, rmax: 0,   pct: 30,  abort_bits: -1, exp_bits: 64};
        vecs[8] = '{m32: 0, lim: 0, rmax: 0,   pct: 100, abort_bits: 11, exp_bits: 11};
        vecs[9] = '{m32: 1, lim: 1, rmax: 7,   pct: 50,  abort_bits: -1, exp_bits: 48};

        mem[0] = 8'hA5; mem[1] = 8'h01; mem[2] = 8'h80; mem[3] = 8'hFF;
        mem[4] = 8'h00; mem[5] = 8'h3C; mem[6] = 8'h5A; mem[7] = 8'hC3;

        busReset     = 1'b1;
        regCtrlRun   = 1'b0;
        regCtrlLimit = 1'b0;
        regCtrl32bit = 1'b0;
        regMax       = '0;
        bitReady     = 1'b0;
        repeat (2) @(posedge busClk);
        @(negedge busClk);
        chk("reset addr", 32'(byteAddr), 32'd0);
        chk("reset flags", {29'd0, state, bitValid, streamSyncOf}, 32'd0);
        @(posedge busClk); #1;
        busReset = 1'b0;

        for (int v = 0; v < 10; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].m32, vecs[v].lim, vecs[v].rmax,
                      vecs[v].pct, vecs[v].abort_bits, 1'b0, 1'b0, vecs[v].exp_bits);
        end

        // Loop mode: second frame restarts two cycles after the sync cycle,
        // then a reset lands mid-DATA of that second frame.
        run_frame("loop", 1'b0, 1'b0, 0, 100, -1, 1'b1, 1'b0, 64);
        repeat (9) begin
            @(posedge busClk); #1;
            bitReady = 1'b1;
        end
        @(negedge busClk);
        chk("pre-reset addr", 32'(byteAddr), 32'd1);
        @(posedge busClk); #1;
        busReset   = 1'b1;
        regCtrlRun = 1'b0;
        bitReady   = 1'b0;
        @(posedge busClk); #1;
        busReset = 1'b0;
        @(negedge busClk);
        chk("data reset addr", 32'(byteAddr), 32'd0);
        chk("data reset flags", {29'd0, state, bitValid, streamSyncOf}, 32'd0);
        for (int i = 0; i < RC + 4; i++) begin
            @(negedge busClk);
            chk("data reset quiet", {29'd0, state, bitValid, streamSyncOf}, 32'd0);
        end

        // Fresh run after reset starts at byte 0, bit 7.
        run_frame("post-reset", 1'b0, 1'b0, 0, 100, -1, 1'b0, 1'b0, 64);

        // Randomized frames with mode bits toggling mid-frame.
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 8; k++) mem[k] = 8'($urandom);
            run_frame($sformatf("rnd%0d", r), 1'($urandom), 1'($urandom),
                      int'($urandom_range(15)), int'($urandom_range(100, 20)),
                      ($urandom_range(3) == 0) ? int'($urandom_range(40, 1)) : -1,
                      1'b0, 1'b1, -1);
        end

        // Reset mid-LATCH: one-byte frame, reset three cycles into LATCH.
        @(posedge busClk); #1;
        regCtrl32bit = 1'b0;
        regCtrlLimit = 1'b1;
        regMax       = '0;
        regCtrlRun   = 1'b1;
        bitReady     = 1'b1;
        repeat (11) @(posedge busClk);
        #1;
        @(negedge busClk);
        chk("in latch", {29'd0, state, bitValid, streamSyncOf}, 32'b100);
        @(posedge busClk); #1;
        busReset   = 1'b1;
        regCtrlRun = 1'b0;
        @(posedge busClk); #1;
        busReset = 1'b0;
        @(negedge busClk);
        chk("latch reset addr", 32'(byteAddr), 32'd0);
        chk("latch reset flags", {29'd0, state, bitValid, streamSyncOf}, 32'd0);
        for (int i = 0; i < RC + 4; i++) begin
            @(negedge busClk);
            chk("latch reset quiet", {29'd0, state, bitValid, streamSyncOf}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/anton_neopixel_stream_sequencer.md
# anton_neopixel_stream_sequencer

Controller that walks the NeoPixel pixel buffer and feeds the bit encoder one bit at a time. It sits between the register block, which supplies the pixel array, `regMax`, and the control bits, and the bit-level waveform encoder. It sequences each frame as DATA followed by LATCH, where LATCH is the low reset period. At frame end it emits `streamSyncOf` so the register block can clear or keep `regCtrlRun` (loop mode).

## Interface
Parameters:
- `BUFFER_END`, default 7: index of the last byte in the pixel buffer.
- `RESET_CYCLES`, default 2500: length of the LATCH period in `busClk` cycles. Must be ≥1.
- `BUFFER_BITS`, localparam `CLOG2(BUFFER_END+1)`.

Ports (clock and reset first):
- `busClk`  in  1  single clock for the whole block.
- `busReset`  in  1  synchronous, active-high reset.
- `regCtrlRun`  in  1  request to stream.
- `regCtrlLimit`  in  1  end the frame at `regMax` instead of `BUFFER_END`.
- `regCtrl32bit`  in  1  4 bytes per pixel; the byte at offset 3 is never sent.
- `regMax`  in  13  last byte index sent when limit mode is on.
- `pixelByte`  in  8  buffer byte at `byteAddr`, combinational from the pixel array.
- `bitReady`  in  1  encoder accepts the current bit.
- `byteAddr`  out  BUFFER_BITS  current buffer byte index.
- `bitValid`  out  1  `bitValue` is valid.
- `bitValue`  out  1  `pixelByte[bitIndex]`, sent MSB first.
- `state`  out  1  1 during LATCH, otherwise 0.
- `streamSyncOf`  out  1  one-cycle pulse at frame end.

## Operation
- **States:** IDLE, DATA, LATCH.
- **Reset values:** IDLE; `byteAddr`=0; internal `bitIndex`=7; `bitValid`=0; `state`=0; `streamSyncOf`=0; latch counter=0; latched mode bits=0.
- **IDLE:**
  - If `regCtrlRun`=1 and `streamSyncOf`=0: latch `regCtrl32bit` and `regCtrlLimit` into internal copies, set `byteAddr`=0, `bitIndex`=7, go to DATA.
  - `regCtrlRun` is ignored in the cycle where `streamSyncOf`=1, because the register block updates run on that edge.
- **DATA:**
  - `bitValid`=1; `bitValue`=`pixelByte[bitIndex]`.
  - A handshake is `bitValid & bitReady` at a clock edge.
  - On a handshake with `bitIndex`>0: decrement `bitIndex`.
  - On a handshake with `bitIndex`=0: the byte is complete.
    - `bitIndex`←7.
    - `nextAddr` = `byteAddr`+2 if 32-bit mode and `byteAddr[1:0]`=2; otherwise `byteAddr`+1.
    - `nextAddr` is computed 14 bits wide so it cannot wrap.
  - `endAddr` = min(`regMax`, `BUFFER_END`) when limit mode is latched; otherwise `BUFFER_END`.
  - If `nextAddr` > `endAddr`: go to LATCH, with `byteAddr` held. Otherwise `byteAddr`←`nextAddr`.
  - In 32-bit mode, byte offsets 0–2 are sent and offset 3 is skipped.
  - If `endAddr` lands on offset 3, the frame ends after offset 2 of that pixel, because `nextAddr` exceeds `endAddr`.
  - **Abort:** if `regCtrlRun`=0 in any DATA cycle, go to LATCH at that edge. A handshake in the same cycle still counts, but the address does not advance further.
  - Mode inputs that change during DATA or LATCH have no effect until the next IDLE→DATA transition.
- **LATCH:**
  - `bitValid`=0; `state`=1.
  - On entry, load the counter with `RESET_CYCLES`−1 and decrement every cycle.
  - At counter 0: go to IDLE and set `streamSyncOf`=1 for exactly the next cycle.
- **Loop mode:** `regCtrlRun` stays high after the sync, so IDLE restarts DATA automatically.
- **busReset mid-frame:** all state returns to reset values at that edge. No `streamSyncOf` pulse and no LATCH period are produced.
- **`regMax`=0 with limit mode:** exactly one byte (8 bits) is sent.

## Timing
- `regCtrlRun` sampled high in IDLE at edge N: `bitValid`=1, `byteAddr`=0, MSB of byte 0 presented in cycle N+1.
- Throughput: at most one bit per cycle. With `bitReady` held high, a byte takes 8 cycles.
- Without a handshake, `byteAddr`, `bitIndex` and `bitValue` hold stable.
- The final handshake at edge M gives `state`=1, `bitValid`=0 from cycle M+1 for exactly `RESET_CYCLES` cycles.
- The next cycle after LATCH has `state`=0 and `streamSyncOf`=1, call it cycle P.
- Loop restart: `bitValid` rises in cycle P+2.
- Abort: `bitValid` falls in the cycle after `regCtrlRun` is first seen low.

## Test plan
1. 24-bit mode, limit off, `BUFFER_END`=5, bytes 0xA5,0x01,0x80,0xFF,0x00,0x3C, `bitReady`=1 → 48 bits MSB first matching the bytes; `state`=1 for `RESET_CYCLES`; exactly one `streamSyncOf`; `regCtrlRun` cleared externally → stays IDLE.
2. 32-bit mode, `BUFFER_END`=7 → `byteAddr` sequence 0,1,2,4,5,6; 48 bits; addresses 3 and 7 never presented.
3. Limit mode, `regMax`=2, `BUFFER_END`=7, 24-bit → 24 bits from bytes 0–2. Then `regMax`=100 → clamps to 64 bits.
4. `bitReady` random 30% duty → `bitValue`/`byteAddr` stable while not ready; bit stream identical to scenario 1.
5. Loop: `regCtrlRun` held high → second frame's first `bitValid` exactly 2 cycles after the `streamSyncOf` cycle. Abort: drop `regCtrlRun` after 11 bits → LATCH next cycle, full `RESET_CYCLES`, then sync.
6. Assert `busReset` mid-DATA and mid-LATCH → all outputs at reset values the next cycle, no `streamSyncOf`. A fresh run starts at byte 0, bit 7.
